// File: rtl/nbyn_pe_tx.sv
// PE-side transmitter for the nbyn switch injection port: stamps local requests
// with a sequence number, queues them and presents them with valid/ready.
`ifndef X_SIZE
`define X_SIZE 2
`endif
`ifndef Y_SIZE
`define Y_SIZE 2
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH (`DATA_WIDTH + `X_SIZE + `Y_SIZE)
`endif

module nbyn_pe_tx #(
   parameter logic [`X_SIZE-1:0] x_coord    = '0,
   parameter logic [`Y_SIZE-1:0] y_coord    = '0,
   parameter int                 FIFO_DEPTH = 4,
   parameter int                 SEQ_WIDTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [`X_SIZE-1:0]                req_dest_x,
   input  logic [`Y_SIZE-1:0]                req_dest_y,
   input  logic [`DATA_WIDTH-SEQ_WIDTH-1:0]  req_payload,
   input  logic                              i_ready,
   output logic                              o_valid,
   output logic [`TOTAL_WIDTH-1:0]           o_data,
   output logic [15:0]                       sent_count,
   output logic [15:0]                       drop_count
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [`TOTAL_WIDTH-1:0] mem_reg [FIFO_DEPTH];
   logic [AW:0]             wr_ptr_reg;
   logic [AW:0]             rd_ptr_reg;
   logic [SEQ_WIDTH-1:0]    seq_reg;
   logic [15:0]             sent_count_reg;
   logic [15:0]             drop_count_reg;

   logic full;
   logic empty;
   logic accept;
   logic self_addr;
   logic push;
   logic pop;

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign empty = (wr_ptr_reg == rd_ptr_reg);

   // Held low while rst is asserted so nothing is accepted in the reset cycle.
   assign req_ready = !full && !rst;
   assign accept    = req_valid && req_ready;
   assign self_addr = (req_dest_x == x_coord) && (req_dest_y == y_coord);
   assign push      = accept && !self_addr;
   assign pop       = o_valid && i_ready;

   assign o_valid    = !empty;
   assign o_data     = empty ? '0 : mem_reg[rd_ptr_reg[AW-1:0]];
   assign sent_count = sent_count_reg;
   assign drop_count = drop_count_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr_reg[AW-1:0]] <= {req_payload, seq_reg, req_dest_y, req_dest_x};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         seq_reg        <= '0;
         sent_count_reg <= '0;
         drop_count_reg <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            seq_reg    <= seq_reg + 1'b1;
         end
         if (accept && self_addr && (drop_count_reg != 16'hFFFF)) begin
            drop_count_reg <= drop_count_reg + 16'd1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (sent_count_reg != 16'hFFFF) begin
               sent_count_reg <= sent_count_reg + 16'd1;
            end
         end
      end
   end

endmodule
